// File: rtl/fusion_pkg.sv
// fusion_pkg: shared precision encodings, FSM states and brick geometry for the fusion multipliers.
package fusion_pkg;
  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;
  localparam int BRICK_W = 2;
  localparam int P_W = 6;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [2:0] bricks_of(input logic [1:0] prec);
    return prec == PREC_2B ? 3'd1 : prec == PREC_4B ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/bitbrick.sv
// bitbrick: 2x2-bit signed/unsigned multiplier with registered 6-bit signed product.
module bitbrick
  import fusion_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BRICK_W-1:0] x,
  input  logic [BRICK_W-1:0] y,
  input  logic               sign_x,
  input  logic               sign_y,
  output logic [P_W-1:0]     p
);
  logic signed [BRICK_W:0] xs, ys;
  assign xs = {sign_x & x[BRICK_W-1], x};
  assign ys = {sign_y & y[BRICK_W-1], y};
  always_ff @(posedge clk)
    p <= reset ? '0 : P_W'(xs * ys);
endmodule

// File: rtl/fusion_serial_mult.sv
// fusion_serial_mult: serial brick-by-brick multiplier driving one bitbrick.
// Define FUSION_ZERO_SKIP_EN to skip brick pairs where either brick is zero.
module fusion_serial_mult
  import fusion_pkg::*;
#(
  parameter int MAX_BITS = 8,
  parameter int ACC_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] a,
  input  logic [MAX_BITS-1:0] b,
  input  logic [1:0]          prec_a,
  input  logic [1:0]          prec_b,
  input  logic                sign_a,
  input  logic                sign_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    product,
  output logic                busy
);
  localparam int NB = MAX_BITS / BRICK_W;
  localparam int NP = NB * NB;
  localparam int IW = $clog2(NB);
  localparam int SH_W = $clog2(ACC_W);
  state_t state, state_nx;
  logic [MAX_BITS-1:0] ra, rb;
  logic [IW-1:0] na_m1, nb_m1, ci, cj;
  logic sa, sb, acc_en;
  logic [NP-1:0] pend, rest, pm;
  logic [2*IW-1:0] idx;
  logic [NB-1:0] nza, nzb;
  logic [SH_W-1:0] sh;
  logic [ACC_W-1:0] acc;
  logic [P_W-1:0] p;
  // Pending pairs are indexed i*NB+j, so lowest-set-bit order is (i,j) with j fastest.
  always_comb begin
    idx = '0;
    for (int k = NP - 1; k >= 0; k--)
      if (pend[k]) idx = (2*IW)'(k);
    nza = '0;
    nzb = '0;
    for (int k = 0; k < NB; k++) begin
`ifdef FUSION_ZERO_SKIP_EN
      nza[k] = (k < int'(bricks_of(prec_a))) && (a[k*BRICK_W +: BRICK_W] != '0);
      nzb[k] = (k < int'(bricks_of(prec_b))) && (b[k*BRICK_W +: BRICK_W] != '0);
`else
      nza[k] = k < int'(bricks_of(prec_a));
      nzb[k] = k < int'(bricks_of(prec_b));
`endif
    end
    pm = '0;
    for (int k = 0; k < NB; k++)
      for (int l = 0; l < NB; l++)
        pm[k*NB+l] = nza[k] & nzb[l];
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = pm != '0 ? RUN : DRAIN;
    if (state == RUN && rest == '0) state_nx = DRAIN;
    if (state == DRAIN) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  assign rest = pend & (pend - 1'b1);
  assign ci = idx[2*IW-1:IW];
  assign cj = idx[IW-1:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign product = acc;
  bitbrick u_brick (
    .clk   (clk),
    .reset (reset),
    .x     (ra[ci*BRICK_W +: BRICK_W]),
    .y     (rb[cj*BRICK_W +: BRICK_W]),
    .sign_x(sa && ci == na_m1),
    .sign_y(sb && cj == nb_m1),
    .p     (p)
  );
  // Shift and enable trail the driven pair by one cycle to line up with the bitbrick register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      na_m1 <= '0;
      nb_m1 <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      pend <= '0;
      acc_en <= 1'b0;
      sh <= '0;
      acc <= '0;
    end else begin
      state <= state_nx;
      acc_en <= state == RUN;
      sh <= SH_W'(({1'b0, ci} + {1'b0, cj}) * BRICK_W);
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
        na_m1 <= IW'(bricks_of(prec_a) - 3'd1);
        nb_m1 <= IW'(bricks_of(prec_b) - 3'd1);
        sa <= sign_a;
        sb <= sign_b;
        pend <= pm;
        acc <= '0;
      end else begin
        if (state == RUN) pend <= rest;
        if (acc_en) acc <= acc + ({{(ACC_W-P_W){p[P_W-1]}}, p} << sh);
      end
    end
  end
endmodule

// File: tb/tb_fusion_serial_mult.sv
// tb_fusion_serial_mult: directed and random checks against an arithmetic reference model.
module tb_fusion_serial_mult;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, sign_a = 0, sign_b = 0;
  logic out_valid, out_ready = 0, busy;
  logic [7:0] a = 0, b = 0;
  logic [1:0] prec_a = 0, prec_b = 0;
  logic [15:0] product;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  fusion_serial_mult dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .prec_a(prec_a), .prec_b(prec_b), .sign_a(sign_a), .sign_b(sign_b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );
  function automatic int width_of(input logic [1:0] pr);
    return pr == 2'b00 ? 2 : pr == 2'b01 ? 4 : 8;
  endfunction
  function automatic longint value_of(input logic [7:0] v, input logic [1:0] pr, input logic s);
    int w = width_of(pr);
    longint x = longint'(v) & ((64'd1 << w) - 1);
    if (s && x[w-1]) x = x - (64'd1 << w);
    return x;
  endfunction
  function automatic logic [15:0] ref_prod(input logic [7:0] x, y, input logic [1:0] px, py, input logic sx, sy);
    longint r = value_of(x, px, sx) * value_of(y, py, sy);
    return r[15:0];
  endfunction
  function automatic int live_bricks(input logic [7:0] v, input logic [1:0] pr);
    int n = 0;
    for (int k = 0; k < width_of(pr) / 2; k++) begin
`ifdef FUSION_ZERO_SKIP_EN
      if (((v >> (2 * k)) & 8'h3) != 0) n++;
`else
      n++;
`endif
    end
    return n;
  endfunction
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic txn(input string tag, input logic [7:0] ta, tb_, input logic [1:0] pa, pb, input logic s1, s2);
    logic [15:0] ep;
    int el, cnt, bad;
    ep = ref_prod(ta, tb_, pa, pb, s1, s2);
    el = live_bricks(ta, pa) * live_bricks(tb_, pb) + 1;
    a = ta; b = tb_; prec_a = pa; prec_b = pb; sign_a = s1; sign_b = s2; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; a = 8'($urandom); b = 8'($urandom); prec_a = 2'($urandom); sign_a = 1'($urandom);
    cnt = 0; bad = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, el);
    chk({tag, "_product"}, product, ep);
    chk({tag, "_rdy_low"}, bad, 0);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_back_idle"}, in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    txn("s2x2", 8'h02, 8'h03, 2'b00, 2'b00, 1, 0);
    txn("u8x8", 8'hFF, 8'hFF, 2'b10, 2'b10, 0, 0);
    txn("s8x8a", 8'h80, 8'h7F, 2'b10, 2'b10, 1, 1);
    txn("s8x8b", 8'hFF, 8'hFF, 2'b11, 2'b10, 1, 1);
    txn("mixed", 8'h09, 8'd100, 2'b01, 2'b10, 1, 0);
    txn("mixed_garbage", 8'hF9, 8'd100, 2'b01, 2'b10, 1, 0);
    txn("one", 8'h01, 8'h01, 2'b10, 2'b10, 0, 0);
    txn("zero", 8'h00, 8'h5A, 2'b10, 2'b10, 0, 1);
    for (int n = 0; n < 24; n++)
      txn("rand", 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    // Backpressure: product must hold while the consumer stalls.
    a = 8'hC3; b = 8'h5E; prec_a = 2'b10; prec_b = 2'b01; sign_a = 1; sign_b = 1; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    for (int n = 0; n < 40 && out_valid !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    for (int n = 0; n < 5; n++) begin
      chk("bp_product", product, ref_prod(8'hC3, 8'h5E, 2'b10, 2'b01, 1, 1));
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    // Reset three cycles into a long run aborts it with no output.
    a = 8'hFF; b = 8'hFF; prec_a = 2'b10; prec_b = 2'b10; sign_a = 0; sign_b = 0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    txn("after_abort", 8'h80, 8'h7F, 2'b10, 2'b10, 1, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
